uart_tx_arbiter: RTL

Round-robin arbiter that shares one `uart_tx` transmitter among `NUM_REQ` requesters at packet granularity. Each requester streams words with a valid/ready handshake and marks the final word with `s_last`. The arbiter sits directly in front of `uart_tx`: `m_vld`/`m_data` drive `i_vld`/`i_data`, and `m_rdy` is driven by `o_rdy`. Each packet is optionally preceded by a header word carrying the requester index, so the far-end `uart_rx` can demultiplex.

---
 rtl/uart_tx_arbiter.sv | 148 ++++++++++++++
 1 files changed

// File: rtl/uart_tx_arbiter.sv
// ============================================================================
// Module   : uart_tx_arbiter
// Purpose  : Packet-granular round-robin arbiter sharing one uart_tx among
//            NUM_REQ valid/ready requesters, with optional requester-index header.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module uart_tx_arbiter #(
    parameter int NUM_REQ    = 4,
    parameter int DATA_WIDTH = 8,
    parameter int HEADER_EN  = 1,
    parameter int MAX_BURST  = 16
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic [NUM_REQ-1:0]              s_vld,
    input  logic [NUM_REQ*DATA_WIDTH-1:0]   s_data,
    input  logic [NUM_REQ-1:0]              s_last,
    output logic [NUM_REQ-1:0]              s_rdy,
    output logic                            m_vld,
    output logic [DATA_WIDTH-1:0]           m_data,
    input  logic                            m_rdy,
    output logic [NUM_REQ-1:0]              grant,
    output logic                            busy
);

    localparam int c_IDX_W = $clog2(NUM_REQ);
    localparam int c_CNT_W = (MAX_BURST == 0) ? 1 : $clog2(MAX_BURST + 1);
    localparam logic [c_CNT_W-1:0] c_BURST_LAST =
        (MAX_BURST == 0) ? '0 : c_CNT_W'(MAX_BURST - 1);
    localparam logic [c_IDX_W-1:0] c_LAST_IDX = c_IDX_W'(NUM_REQ - 1);

    generate
        if (DATA_WIDTH < $clog2(NUM_REQ)) begin : g_width_check
            $fatal(1, "uart_tx_arbiter: DATA_WIDTH too small to carry requester index");
        end
    endgenerate

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_HEADER = 2'd1,
        S_DATA   = 2'd2
    } state_t;

    state_t                  r_state;
    state_t                  w_state_nxt;
    logic [c_IDX_W-1:0]      r_ptr;
    logic [c_IDX_W-1:0]      r_owner;
    logic [c_CNT_W-1:0]      r_cnt;
    logic [NUM_REQ-1:0]      r_grant;

    logic [c_IDX_W-1:0]      w_sel;
    logic [c_IDX_W-1:0]      w_cand;
    logic                    w_found;
    logic                    w_any;
    logic                    w_start;
    logic                    w_data_xfer;
    logic                    w_burst_end;
    logic                    w_exit;
    logic [DATA_WIDTH-1:0]   w_owner_data;
    logic [c_IDX_W-1:0]      w_ptr_nxt;

    assign w_any        = |s_vld;
    assign w_start      = (r_state == S_IDLE) && w_any;
    assign w_owner_data = s_data[r_owner*DATA_WIDTH +: DATA_WIDTH];
    assign w_data_xfer  = (r_state == S_DATA) && s_vld[r_owner] && m_rdy;
    assign w_burst_end  = (MAX_BURST != 0) && (r_cnt == c_BURST_LAST);
    assign w_ptr_nxt    = (r_owner == c_LAST_IDX) ? '0 : r_owner + 1'b1;

    // First requesting index at or above ptr, wrapping around.
    always_comb begin
        w_sel   = r_ptr;
        w_cand  = r_ptr;
        w_found = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            w_cand = c_IDX_W'((int'(r_ptr) + i) % NUM_REQ);
            if (!w_found && s_vld[w_cand]) begin
                w_sel   = w_cand;
                w_found = 1'b1;
            end
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        m_vld       = 1'b0;
        m_data      = '0;
        s_rdy       = '0;
        w_exit      = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_any) begin
                    w_state_nxt = (HEADER_EN != 0) ? S_HEADER : S_DATA;
                end
            end
            S_HEADER: begin
                m_vld  = 1'b1;
                m_data = DATA_WIDTH'(r_owner);
                if (m_rdy) begin
                    w_state_nxt = S_DATA;
                end
            end
            S_DATA: begin
                m_vld          = s_vld[r_owner];
                m_data         = w_owner_data;
                s_rdy[r_owner] = m_rdy;
                // Packet end and burst limit share one exit path.
                if (w_data_xfer && (s_last[r_owner] || w_burst_end)) begin
                    w_exit      = 1'b1;
                    w_state_nxt = S_IDLE;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= S_IDLE;
            r_ptr   <= '0;
            r_owner <= '0;
            r_cnt   <= '0;
            r_grant <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (w_start) begin
                r_owner <= w_sel;
                r_grant <= NUM_REQ'(1) << w_sel;
                r_cnt   <= '0;
            end else if (w_data_xfer) begin
                r_cnt <= r_cnt + 1'b1;
            end
            if (w_exit) begin
                r_ptr   <= w_ptr_nxt;
                r_grant <= '0;
            end
        end
    end

    assign grant = r_grant;
    assign busy  = (r_state != S_IDLE);

endmodule

`default_nettype wire
